// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receiver, sender and receive FIFO.
package uart_pkg;

  // Byte width shared by receiver, sender and FIFO.
  localparam int unsigned UART_DATA_WIDTH = 8;

  // Default bit period in system clocks.
  localparam int unsigned CLKS_PER_BIT = 87;

  typedef logic [7:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO fed by the UART receiver's data-valid strobe.
// A rising edge on i_rx_dv writes one byte; reads return data one clock after i_rd_en.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rx_dv,
  input  logic [DATA_WIDTH-1:0]   i_rx_byte,
  input  logic                    i_rd_en,
  input  logic                    i_clr_ovf,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  logic                  dv_q;
  logic                  ovf_q, ovf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic wr_req, rd_acc, wr_acc, ovf_set;

  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == cnt_t'(DEPTH));
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

  // Handshake decode and next-state for pointers, occupancy, read port and overflow flag.
  always_comb begin
    wr_req  = i_rx_dv & ~dv_q;
    rd_acc  = i_rd_en & ~o_empty;
    // When full, a same-cycle read frees the slot the write needs.
    wr_acc  = wr_req & (~o_full | rd_acc);
    ovf_set = wr_req & o_full & ~rd_acc;

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);

    rd_ptr_d = rd_ptr_q;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;

    // Set has priority over clear.
    if (ovf_set)        ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dv_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dv_q       <= i_rx_dv;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_rst) mem[wr_ptr_q] <= i_rx_byte;
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, rx_dv, rd_en, clr_ovf;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_data;
  logic          rd_valid, empty, full, overflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] q[$];
  logic       m_prev, m_ovf, m_valid;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (UART_DATA_WIDTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_dv    (rx_dv),
    .i_rx_byte  (rx_byte),
    .i_rd_en    (rd_en),
    .i_clr_ovf  (clr_ovf),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow)
  );

  typedef struct {
    logic       rst, dv;
    logic [7:0] b;
    logic       rd, clr;
    int         cnt;
    logic       emp, ful, vld;
    logic [7:0] dat;
    logic       ovf;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic dv, input logic [7:0] b, input logic rd,
                       input logic clr);
    rst = r; rx_dv = dv; rx_byte = b; rd_en = rd; clr_ovf = clr;
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT, compare.
  task automatic step(input string tag);
    logic wr, rd, fl, set;
    if (rst) begin
      q.delete();
      m_prev = 1'b0; m_ovf = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    end else begin
      wr     = rx_dv && !m_prev;
      m_prev = rx_dv;
      rd     = rd_en && (q.size() != 0);
      fl     = (q.size() == DEPTH);
      set    = wr && fl && !rd;
      if (rd) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr && (!fl || rd)) q.push_back(rx_byte);
      if (set) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, " count"},    32'(count),    32'(q.size()));
    chk({tag, " empty"},    32'(empty),    32'(q.size() == 0));
    chk({tag, " full"},     32'(full),     32'(q.size() == DEPTH));
    chk({tag, " valid"},    32'(rd_valid), 32'(m_valid));
    chk({tag, " data"},     32'(rd_data),  32'(m_data));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic push_byte(input logic [7:0] b, input string tag);
    drive(0, 1, b, 0, 0); step(tag);
    drive(0, 0, b, 0, 0); step(tag);
  endtask

  task automatic do_reset();
    drive(1, 0, 8'h00, 0, 0); step("rst");
    step("rst");
    drive(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    //            rst dv  byte   rd clr  cnt emp ful vld data   ovf
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0};
    vecs[1]  = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0};
    vecs[2]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0};
    vecs[3]  = '{0, 1, 8'h11, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    vecs[4]  = '{0, 1, 8'h22, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    vecs[5]  = '{0, 1, 8'h33, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    vecs[6]  = '{0, 1, 8'h44, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    vecs[7]  = '{0, 1, 8'h55, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    vecs[8]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h11, 0};
    vecs[9]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h11, 0};
    vecs[10] = '{0, 1, 8'h5A, 1, 0, 1, 0, 0, 0, 8'h11, 0};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h5A, 0};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h5A, 0};
    vecs[13] = '{0, 1, 8'hC3, 0, 0, 1, 0, 0, 0, 8'h5A, 0};
    vecs[14] = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h5A, 0};
    vecs[15] = '{0, 1, 8'h7E, 1, 0, 1, 0, 0, 1, 8'hC3, 0};
    vecs[16] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h7E, 0};
    vecs[17] = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h7E, 0};

    drive(1, 0, 8'h00, 0, 0);

    // Table-driven vectors: level-held dv, empty read, write-while-empty, simultaneous r/w.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].dv, vecs[i].b, vecs[i].rd, vecs[i].clr);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl count", i), 32'(count),    32'(vecs[i].cnt));
      chk($sformatf("vec%0d tbl empty", i), 32'(empty),    32'(vecs[i].emp));
      chk($sformatf("vec%0d tbl full", i),  32'(full),     32'(vecs[i].ful));
      chk($sformatf("vec%0d tbl valid", i), 32'(rd_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d tbl data", i),  32'(rd_data),  32'(vecs[i].dat));
      chk($sformatf("vec%0d tbl ovf", i),   32'(overflow), 32'(vecs[i].ovf));
    end

    // Fill and overflow, then drain in order; 0xEE must never appear.
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i), "fill");
    push_byte(8'hEE, "ovf");
    chk("ovf full", 32'(full), 32'd1);
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf flag", 32'(overflow), 32'd1);
    // Overflow and clear in the same cycle: set wins.
    drive(0, 1, 8'hEF, 0, 1); step("ovf+clr");
    chk("ovf set wins", 32'(overflow), 32'd1);
    drive(0, 0, 8'h00, 0, 1); step("clr");
    chk("ovf cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0); step("drain");
      chk("drain valid", 32'(rd_valid), 32'd1);
      chk("drain data", 32'(rd_data), 32'(i));
    end
    drive(0, 0, 8'h00, 0, 0); step("drained");
    chk("drained empty", 32'(empty), 32'd1);

    // Full with simultaneous read and write: 0x77 accepted, read last after wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), "fill2");
    drive(0, 1, 8'h77, 1, 0); step("full rw");
    chk("full rw count", 32'(count), 32'd16);
    chk("full rw ovf", 32'(overflow), 32'd0);
    chk("full rw data", 32'(rd_data), 32'h80);
    for (int i = 1; i < 17; i++) begin
      drive(0, 0, 8'h00, 1, 0); step("drain2");
      chk("drain2 data", 32'(rd_data), (i == 16) ? 32'h77 : 32'(8'h80 + i));
    end

    // Reset mid-stream with a read pending.
    for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i), "pre-rst");
    drive(1, 0, 8'h00, 1, 0); step("rst+rd");
    chk("rst+rd count", 32'(count), 32'd0);
    chk("rst+rd empty", 32'(empty), 32'd1);
    chk("rst+rd valid", 32'(rd_valid), 32'd0);
    drive(0, 0, 8'h00, 1, 0); step("post-rst rd");
    chk("post-rst valid", 32'(rd_valid), 32'd0);

    // dv held through reset counts as an edge in the first cycle after reset.
    drive(1, 1, 8'h9C, 0, 0); step("rst dv");
    drive(0, 1, 8'h9C, 0, 0); step("dv after rst");
    chk("dv after rst count", 32'(count), 32'd1);
    drive(0, 0, 8'h00, 1, 0); step("dv after rst rd");
    chk("dv after rst data", 32'(rd_data), 32'h9C);

    // Randomized traffic: write-heavy phase then read-heavy phase.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
            (i < 1500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 49) == 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
